bitrev_share_arb: RTL and testbench
===================================

Name: bitrev_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one bit-reversal datapath (c = bit-reverse(a)) between two requesters.
- Each requester presents a WIDTH-bit operand with a valid/ready handshake. The winner's operand is reversed and registered into a single output slot, tagged with the requester id.
- Sits between the two operand producers and one downstream consumer, and replaces a dedicated reverse unit per requester.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..32.
- CNT_W, 8, width of the per-requester saturating grant counters.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in0_valid  input  1  requester 0 operand valid
- in0_ready  output  1  requester 0 operand accepted this cycle (when valid)
- in0_data  input  WIDTH  requester 0 operand
- in1_valid  input  1  requester 1 operand valid
- in1_ready  output  1  requester 1 operand accepted this cycle (when valid)
- in1_data  input  WIDTH  requester 1 operand
- out_valid  output  1  result slot holds a result
- out_ready  input  1  consumer takes result this cycle
- out_data  output  WIDTH  bit-reversed operand: out_data[i] = operand[WIDTH-1-i]
- out_id  output  1  requester index the result belongs to
- grant_cnt0  output  CNT_W  saturating count of requester 0 acceptances
- grant_cnt1  output  CNT_W  saturating count of requester 1 acceptances

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_id=0.
  - grant_cnt0 = grant_cnt1 = 0.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
- Slot free condition: free = !out_valid | out_ready (combinational; drain and refill in the same cycle is allowed).
- Arbitration (combinational, from in*_valid and last):
  - Only in0_valid -> gnt0. Only in1_valid -> gnt1.
  - Both valid -> grant the requester != last. Neither valid -> no grant.
- Ready generation:
  - inK_ready = free & gntK. Never both high.
  - A ready never goes high for a non-valid requester.
  - Ready is independent of the inK_data value.
- Accept: on a clock edge with inK_valid & inK_ready:
  - out_data <= bit-reverse(inK_data); out_id <= K; out_valid <= 1.
  - last <= K.
  - grant_cntK increments, saturating at 2^CNT_W-1 (holds, no wrap).
- Drain: out_valid & out_ready with no accept -> out_valid <= 0. out_data/out_id hold their stale values.
- Stall: out_valid & !out_ready:
  - out_data, out_id and out_valid hold.
  - Both readies are 0; last is unchanged.
- Latency and throughput:
  - An operand accepted at edge N is visible on out_* after edge N (one-cycle latency).
  - Sustained throughput is 1 result/cycle when out_ready=1.
  - Under continuous dual requests, grants alternate 0,1,0,1...
- Requester obligations (checked by assertions in the bench, not by RTL):
  - A requester holding valid without ready must keep data stable.
  - Withdrawing valid is tolerated by the RTL.
- Reset mid-operation: an in-flight result is discarded (out_valid=0 immediately). No acceptance occurs in the cycle reset deasserts unless a valid is present at the next edge.
- No combinational path from out_ready to out_valid/out_data.
- The path out_ready -> inK_ready is combinational and intended.

Decomposition:
- Shared package bitrev_pkg:
  - parameter default WIDTH_DEF=4
  - typedef req_id_t (1-bit)
  - function bit_reverse(input logic [WIDTH-1:0]) returning the reversed vector
- Sub-module rr_arb2:
  - Two-input round-robin arbiter owning the last pointer.
  - Inputs: req[1:0], advance (accept strobe), winner id.
  - Output: gnt[1:0].
- Datapath, output register and counters stay in the top module.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> out_valid=0, both readies 0, both counters 0. Release; in0_valid=1, in0_data=4'b1010 -> next cycle out_valid=1, out_data=4'b0101, out_id=0.
- Contention alternation: both valid continuously (in0=4'b0001, in1=4'b1100), out_ready=1 for 6 cycles:
  - Results alternate id 0,1,0,1,0,1 with data 4'b1000 / 4'b0011.
  - grant_cnt0 = grant_cnt1 = 3.
- Backpressure:
  - Accept 4'b0110 from requester 1, then out_ready=0 for 3 cycles -> out_data=4'b0110, out_id=1 held; in0_ready=in1_ready=0 throughout.
  - Raise out_ready with in0_valid=1, in0_data=4'b0011 -> same-cycle drain and refill; next cycle out_data=4'b1100, out_id=0.
- Idle drain: single accept of 4'b1111, then no requests with out_ready=1 -> out_valid drops after one cycle; counters unchanged afterwards.
- Saturation: CNT_W=2, 5 consecutive in0 acceptances -> grant_cnt0 = 3 and holds; grant_cnt1 = 0.
- Mid-operation reset: pulse rst_n low asynchronously between edges while out_valid=1 -> out_valid=0 immediately. After release, dual request -> requester 0 granted first.

Source files
------------

// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the shared bit-reversal arbiter.
package bitrev_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int WIDTH_MAX = 32;

    typedef logic req_id_t;

    // Reverse the low w bits of v into the low w bits of the result; upper bits are zero.
    function automatic logic [WIDTH_MAX-1:0] bit_reverse(input logic [WIDTH_MAX-1:0] v,
                                                         input int w);
        logic [WIDTH_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH_MAX; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_share_arb_if.sv
// Handshake bundle: two operand requesters in, one result slot out.
interface bitrev_share_arb_if
    import bitrev_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    req_id_t          out_id;

    // Producers and consumer side
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_id
    );

    // Arbiter side
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; owns the pointer to the most recent winner.
module rr_arb2
    import bitrev_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  req_id_t    winner,
    output logic [1:0] gnt
);
    req_id_t last;

    // Pointer moves to the requester that was actually accepted; starts at 1 so 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= winner;
        end
    end

    // Lone requester always wins; under contention the one that did not win last goes.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/bitrev_share_arb.sv
// One bit-reversal datapath shared by two requesters with a single tagged result slot.
module bitrev_share_arb
    import bitrev_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    bitrev_share_arb_if.slave bus,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    logic [1:0]       gnt;
    logic             free;
    logic             acc0;
    logic             acc1;
    logic             accept;
    req_id_t          win_id;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] rev_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.in1_valid, bus.in0_valid}),
        .advance (accept),
        .winner  (win_id),
        .gnt     (gnt)
    );

    // Slot can take a new result when empty or being drained this cycle; readies stay low in reset.
    always_comb begin
        free          = !bus.out_valid | bus.out_ready;
        bus.in0_ready = rst_n & free & gnt[0];
        bus.in1_ready = rst_n & free & gnt[1];
        acc0          = bus.in0_valid & bus.in0_ready;
        acc1          = bus.in1_valid & bus.in1_ready;
        accept        = acc0 | acc1;
        win_id        = acc1;
        sel_data      = gnt[1] ? bus.in1_data : bus.in0_data;
        rev_data      = WIDTH'(bit_reverse(32'(sel_data), WIDTH));
    end

    // Output slot: load on accept, empty on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= rev_data;
            bus.out_id    <= win_id;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Per-requester acceptance counters that stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (acc0) grant_cnt0 <= sat_inc(grant_cnt0);
            if (acc1) grant_cnt1 <= sat_inc(grant_cnt1);
        end
    end

endmodule

// File: tb/tb_bitrev_share_arb.sv
// Directed bench for bitrev_share_arb (WIDTH=4, CNT_W=2 so saturation is reachable).
module tb_bitrev_share_arb;
    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;
    int               checks = 0;
    int               errors = 0;

    bitrev_share_arb_if #(.WIDTH(WIDTH)) bus ();

    bitrev_share_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Requester obligation: data held stable while valid waits for ready.
    logic             stall0_q = 1'b0, stall1_q = 1'b0;
    logic [WIDTH-1:0] d0_q = '0, d1_q = '0;
    always @(posedge clk) begin
        if (rst_n && stall0_q && bus.in0_valid) begin
            checks++;
            if (bus.in0_data !== d0_q) begin errors++; $display("FAIL req0_stable got %b want %b", bus.in0_data, d0_q); end
        end
        if (rst_n && stall1_q && bus.in1_valid) begin
            checks++;
            if (bus.in1_data !== d1_q) begin errors++; $display("FAIL req1_stable got %b want %b", bus.in1_data, d1_q); end
        end
        stall0_q <= rst_n & bus.in0_valid & !bus.in0_ready;
        stall1_q <= rst_n & bus.in1_valid & !bus.in1_ready;
        d0_q     <= bus.in0_data;
        d1_q     <= bus.in1_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in0_valid = 1'b0; bus.in0_data = '0;
        bus.in1_valid = 1'b0; bus.in1_data = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in0_valid = 1'($urandom_range(0, 1));
            bus.in1_valid = 1'($urandom_range(0, 1));
            bus.in0_data  = 4'($urandom);
            bus.in1_data  = 4'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
            checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b00) begin errors++; $display("FAIL rst_readies got %b want 00", {bus.in1_ready, bus.in0_ready}); end
            checks++; if ({grant_cnt1, grant_cnt0} !== 4'h0) begin errors++; $display("FAIL rst_counters got %h want 0", {grant_cnt1, grant_cnt0}); end
        end
        checks++; if (bus.out_data !== 4'b0000) begin errors++; $display("FAIL rst_out_data got %b want 0000", bus.out_data); end
        checks++; if (bus.out_id !== 1'b0) begin errors++; $display("FAIL rst_out_id got %b want 0", bus.out_id); end
        idle_inputs();
        rst_n = 1'b1;
        bus.in0_valid = 1'b1; bus.in0_data = 4'b1010; bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in0_ready !== 1'b1) begin errors++; $display("FAIL rst_first_ready got %b want 1", bus.in0_ready); end
        tick();
        bus.in0_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_first_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 4'b0101) begin errors++; $display("FAIL rst_first_data got %b want 0101", bus.out_data); end
        checks++; if (bus.out_id !== 1'b0) begin errors++; $display("FAIL rst_first_id got %b want 0", bus.out_id); end
        checks++; if (grant_cnt0 !== 2'd1) begin errors++; $display("FAIL rst_first_cnt0 got %0d want 1", grant_cnt0); end
    endtask

    task automatic test_contention();
        logic             exp_id;
        logic [WIDTH-1:0] exp_data;
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_data = 4'b0001;
        bus.in1_valid = 1'b1; bus.in1_data = 4'b1100;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id   = 1'(i % 2);
            exp_data = exp_id ? 4'b0011 : 4'b1000;
            #1;
            checks++; if ({bus.in1_ready, bus.in0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_ready[%0d] got %b want %b", i, {bus.in1_ready, bus.in0_ready}, exp_id ? 2'b10 : 2'b01); end
            tick();
            checks++; if (bus.out_id !== exp_id) begin errors++; $display("FAIL cont_id[%0d] got %b want %b", i, bus.out_id, exp_id); end
            checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL cont_data[%0d] got %b want %b", i, bus.out_data, exp_data); end
        end
        idle_inputs();
        checks++; if (grant_cnt0 !== 2'd3) begin errors++; $display("FAIL cont_cnt0 got %0d want 3", grant_cnt0); end
        checks++; if (grant_cnt1 !== 2'd3) begin errors++; $display("FAIL cont_cnt1 got %0d want 3", grant_cnt1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.in1_valid = 1'b1; bus.in1_data = 4'b0110; bus.out_ready = 1'b1;
        tick();
        bus.in1_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_data = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b00) begin errors++; $display("FAIL bp_readies[%0d] got %b want 00", i, {bus.in1_ready, bus.in0_ready}); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_data !== 4'b0110) begin errors++; $display("FAIL bp_data[%0d] got %b want 0110", i, bus.out_data); end
            checks++; if (bus.out_id !== 1'b1) begin errors++; $display("FAIL bp_id[%0d] got %b want 1", i, bus.out_id); end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in0_ready !== 1'b1) begin errors++; $display("FAIL bp_refill_ready got %b want 1", bus.in0_ready); end
        tick();
        bus.in0_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_refill_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 4'b1100) begin errors++; $display("FAIL bp_refill_data got %b want 1100", bus.out_data); end
        checks++; if (bus.out_id !== 1'b0) begin errors++; $display("FAIL bp_refill_id got %b want 0", bus.out_id); end
        checks++; if ({grant_cnt1, grant_cnt0} !== {2'd1, 2'd1}) begin errors++; $display("FAIL bp_counters got %h want 5", {grant_cnt1, grant_cnt0}); end
        idle_inputs();
    endtask

    task automatic test_idle_drain();
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_data = 4'b1111; bus.out_ready = 1'b1;
        tick();
        bus.in0_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_loaded got %b want 1", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'b1111) begin errors++; $display("FAIL drain_stale_data got %b want 1111", bus.out_data); end
        tick();
        checks++; if (grant_cnt0 !== 2'd1) begin errors++; $display("FAIL drain_cnt0 got %0d want 1", grant_cnt0); end
        checks++; if (grant_cnt1 !== 2'd0) begin errors++; $display("FAIL drain_cnt1 got %0d want 0", grant_cnt1); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_data = 4'b0101; bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++; if (grant_cnt0 !== exp_cnt) begin errors++; $display("FAIL sat_cnt0[%0d] got %0d want %0d", i, grant_cnt0, exp_cnt); end
        end
        bus.in0_valid = 1'b0;
        tick();
        checks++; if (grant_cnt0 !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", grant_cnt0); end
        checks++; if (grant_cnt1 !== 2'd0) begin errors++; $display("FAIL sat_cnt1 got %0d want 0", grant_cnt1); end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_data = 4'b0001; bus.out_ready = 1'b0;
        tick();
        bus.in0_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got %b want 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'b0000) begin errors++; $display("FAIL mid_async_data got %b want 0000", bus.out_data); end
        tick();
        rst_n = 1'b1;
        bus.in0_valid = 1'b1; bus.in0_data = 4'b0010;
        bus.in1_valid = 1'b1; bus.in1_data = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        checks++; if ({bus.in1_ready, bus.in0_ready} !== 2'b01) begin errors++; $display("FAIL mid_first_ready got %b want 01", {bus.in1_ready, bus.in0_ready}); end
        tick();
        idle_inputs();
        checks++; if (bus.out_id !== 1'b0) begin errors++; $display("FAIL mid_first_id got %b want 0", bus.out_id); end
        checks++; if (bus.out_data !== 4'b0100) begin errors++; $display("FAIL mid_first_data got %b want 0100", bus.out_data); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_contention();
        test_backpressure();
        test_idle_drain();
        test_saturation();
        test_mid_reset();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
